systolic_feeder: RTL and testbench

Operand staging and skew stage directly upstream of the 4x4 systolic tile. It holds one A matrix and one B matrix, loaded row by row. On `start` it clears the array accumulators, then drives the row-edge inputs (x) and column-edge inputs (w) with the diagonally skewed operand wavefront for C = A·B. It then flushes zeros until the last partial products have drained and pulses `done`.

---
 rtl/systolic_feeder.sv | 219 +++++++++++++++++++++
 tb/tb_systolic_feeder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//
// Operand staging and skew stage in front of a SIZE x SIZE systolic tile.
// Holds one A and one B matrix (loaded one row per handshake). A compute
// pass clears the array accumulators, drives the diagonally skewed operand
// wavefront for C = A*B, flushes zeros while the array drains, then pulses
// done.
//
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low; clears state, outputs, matrices
//   load_valid  : row load request
//   load_ready  : high only while idle (decoded from state)
//   load_sel    : 0 = matrix A, 1 = matrix B
//   load_row    : row index being written
//   load_data   : row elements, element k at [k*WIDTH +: WIDTH]
//   start       : begin a pass (only honoured while idle)
//   busy        : high in every state except idle (decoded from state)
//   acc_clear   : one-cycle accumulator clear pulse
//   feed_valid  : high on the 2*SIZE-1 operand beats
//   x0..x3      : row-edge operands, array rows 0..3
//   w0..w3      : column-edge operands, array columns 0..3
//   done        : one-cycle pulse once array results are final
//
// The x/w port list is fixed at four lanes, so SIZE is expected to be 4.
// ---------------------------------------------------------------------------
module systolic_feeder #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 8,
  parameter int DRAIN = SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    load_sel,
  input  logic [$clog2(SIZE)-1:0] load_row,
  input  logic [SIZE*WIDTH-1:0]   load_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    acc_clear,
  output logic                    feed_valid,
  output logic [WIDTH-1:0]        x0,
  output logic [WIDTH-1:0]        x1,
  output logic [WIDTH-1:0]        x2,
  output logic [WIDTH-1:0]        x3,
  output logic [WIDTH-1:0]        w0,
  output logic [WIDTH-1:0]        w1,
  output logic [WIDTH-1:0]        w2,
  output logic [WIDTH-1:0]        w3,
  output logic                    done
);

  localparam int RW      = $clog2(SIZE);
  localparam int CNT_MAX = ((2*SIZE - 1) > DRAIN) ? (2*SIZE - 1) : DRAIN;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     feed_t_s;
  logic              load_fire_s;

  logic [WIDTH-1:0]  a_r     [SIZE][SIZE];
  logic [WIDTH-1:0]  b_r     [SIZE][SIZE];
  logic [WIDTH-1:0]  x_r     [SIZE];
  logic [WIDTH-1:0]  w_r     [SIZE];
  logic [WIDTH-1:0]  x_nxt_s [SIZE];
  logic [WIDTH-1:0]  w_nxt_s [SIZE];

  logic              acc_clear_r;
  logic              feed_valid_r;
  logic              done_r;

  // Handshake/status decode straight from the state register.
  assign load_ready  = (state_r == S_IDLE);
  assign busy        = (state_r != S_IDLE);
  assign load_fire_s = load_valid && load_ready;

  // Beat index of the beat being registered at the next edge: the first
  // beat is loaded while leaving CLEAR, later beats while in FEED.
  always_comb begin
    if (state_r == S_CLEAR) begin
      feed_t_s = {CW{1'b0}};
    end else begin
      feed_t_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Diagonal skew: row i sees A[i][t-i], column j sees B[t-j][j], zero
  // outside the matrix.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      x_nxt_s[i] = {WIDTH{1'b0}};
      w_nxt_s[i] = {WIDTH{1'b0}};
      for (int k = 0; k < SIZE; k++) begin
        x_nxt_s[i] = (feed_t_s == CW'(i + k)) ? a_r[i][k] : x_nxt_s[i];
        w_nxt_s[i] = (feed_t_s == CW'(i + k)) ? b_r[k][i] : w_nxt_s[i];
      end
    end
  end

  // Operand storage: one row written per accepted load handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int k = 0; k < SIZE; k++) begin
          a_r[r][k] <= {WIDTH{1'b0}};
          b_r[r][k] <= {WIDTH{1'b0}};
        end
      end
    end else begin
      for (int r = 0; r < SIZE; r++) begin
        for (int k = 0; k < SIZE; k++) begin
          if (load_fire_s && (load_row == RW'(r)) && !load_sel) begin
            a_r[r][k] <= load_data[k*WIDTH +: WIDTH];
          end
          if (load_fire_s && (load_row == RW'(r)) && load_sel) begin
            b_r[r][k] <= load_data[k*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Sequencer: state, beat/drain counter and all registered outputs. Each
  // output is computed for the state being entered so it appears in that
  // state's cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= {CW{1'b0}};
      acc_clear_r  <= 1'b0;
      feed_valid_r <= 1'b0;
      done_r       <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        x_r[i] <= {WIDTH{1'b0}};
        w_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      acc_clear_r  <= 1'b0;
      feed_valid_r <= 1'b0;
      done_r       <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        x_r[i] <= {WIDTH{1'b0}};
        w_r[i] <= {WIDTH{1'b0}};
      end
      case (state_r)
        S_IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (start) begin
            state_r     <= S_CLEAR;
            acc_clear_r <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CLEAR: begin
          state_r      <= S_FEED;
          cnt_r        <= {CW{1'b0}};
          feed_valid_r <= 1'b1;
          x_r          <= x_nxt_s;
          w_r          <= w_nxt_s;
        end
        S_FEED: begin
          if (cnt_r == CW'(2*SIZE - 2)) begin
            state_r <= S_FLUSH;
            cnt_r   <= {CW{1'b0}};
          end else begin
            state_r      <= S_FEED;
            cnt_r        <= feed_t_s;
            feed_valid_r <= 1'b1;
            x_r          <= x_nxt_s;
            w_r          <= w_nxt_s;
          end
        end
        S_FLUSH: begin
          if (cnt_r == CW'(DRAIN - 1)) begin
            state_r <= S_DONE;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b1;
          end else begin
            state_r <= S_FLUSH;
            cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          cnt_r   <= {CW{1'b0}};
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign acc_clear  = acc_clear_r;
  assign feed_valid = feed_valid_r;
  assign done       = done_r;
  assign x0 = x_r[0];
  assign x1 = x_r[1];
  assign x2 = x_r[2];
  assign x3 = x_r[3];
  assign w0 = w_r[0];
  assign w1 = w_r[1];
  assign w2 = w_r[2];
  assign w3 = w_r[3];

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int SIZE  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  reset;
  logic                  load_valid;
  logic                  load_ready;
  logic                  load_sel;
  logic [1:0]            load_row;
  logic [SIZE*WIDTH-1:0] load_data;
  logic                  start;
  logic                  busy;
  logic                  acc_clear;
  logic                  feed_valid;
  logic [WIDTH-1:0]      x0, x1, x2, x3;
  logic [WIDTH-1:0]      w0, w1, w2, w3;
  logic                  done;

  int n_checks;
  int n_errors;

  // Reference matrices as written by accepted loads.
  logic [7:0] ref_a [4][4];
  logic [7:0] ref_b [4][4];

  systolic_feeder #(.SIZE(SIZE), .WIDTH(WIDTH), .DRAIN(SIZE)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
    .load_row(load_row), .load_data(load_data),
    .start(start), .busy(busy), .acc_clear(acc_clear), .feed_valid(feed_valid),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_x(input int i, input int t);
    int d;
    d = t - i;
    if (d >= 0 && d < 4) return ref_a[i][d];
    return 8'd0;
  endfunction

  function automatic logic [7:0] exp_w(input int j, input int t);
    int d;
    d = t - j;
    if (d >= 0 && d < 4) return ref_b[d][j];
    return 8'd0;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        ref_a[r][k] = 8'd0;
        ref_b[r][k] = 8'd0;
      end
  endtask

  task automatic model_write(input logic sel, input int row, input logic [31:0] data);
    for (int k = 0; k < 4; k++) begin
      if (!sel) ref_a[row][k] = data[k*8 +: 8];
      else      ref_b[row][k] = data[k*8 +: 8];
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_xw"}, {x3, x2, x1, x0, w3, w2, w1, w0} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    check_val({tag, "_ctl"}, {27'd0, acc_clear, feed_valid, done, busy, load_ready}, 32'd1);
  endtask

  // Check every output in cycle c after the start-sampling edge.
  task automatic check_cycle(input int c);
    logic [31:0] ex_x, ex_w;
    int t;
    bit in_feed;
    in_feed = (c >= 2 && c <= 8);
    t = c - 2;
    ex_x = 32'd0;
    ex_w = 32'd0;
    if (in_feed) begin
      for (int i = 0; i < 4; i++) begin
        ex_x[i*8 +: 8] = exp_x(i, t);
        ex_w[i*8 +: 8] = exp_w(i, t);
      end
    end
    check_val($sformatf("acc_clear_c%0d", c), {31'd0, acc_clear}, {31'd0, c == 1});
    check_val($sformatf("feed_valid_c%0d", c), {31'd0, feed_valid}, {31'd0, in_feed});
    check_val($sformatf("done_c%0d", c), {31'd0, done}, {31'd0, c == 13});
    check_val($sformatf("busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 13});
    check_val($sformatf("load_ready_c%0d", c), {31'd0, load_ready}, {31'd0, c >= 14});
    check_val($sformatf("x_c%0d", c), {x3, x2, x1, x0}, ex_x);
    check_val($sformatf("w_c%0d", c), {w3, w2, w1, w0}, ex_w);
  endtask

  task automatic do_load(input logic sel, input int row, input logic [31:0] data);
    @(negedge clk);
    load_valid = 1'b1;
    load_sel   = sel;
    load_row   = row[1:0];
    load_data  = data;
    model_write(sel, row, data);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // One full pass. Entered and left at a negedge with the DUT idle.
  // gate_mode: 0 quiet, 1 random load attempts, 2 A row0 = 0xFF attempts.
  task automatic run_pass(input int gate_mode, input bit collide, input logic [31:0] cdata);
    start = 1'b1;
    if (collide) begin
      load_valid = 1'b1;
      load_sel   = 1'b0;
      load_row   = 2'd0;
      load_data  = cdata;
      model_write(1'b0, 0, cdata);
    end
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_cycle(c);
      if (c <= 13 && gate_mode == 1) begin
        load_valid = 1'($urandom);
        load_sel   = 1'($urandom);
        load_row   = 2'($urandom);
        load_data  = $urandom;
      end else if (c <= 13 && gate_mode == 2) begin
        load_valid = 1'b1;
        load_sel   = 1'b0;
        load_row   = 2'd0;
        load_data  = 32'hFFFF_FFFF;
      end else begin
        load_valid = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    clear_model();
    reset      = 1'b0;
    start      = 1'b0;
    load_valid = 1'b0;
    load_sel   = 1'b0;
    load_row   = 2'd0;
    load_data  = 32'd0;

    // Reset with random inputs toggling.
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check_zero_outputs("rst");
      start      = 1'($urandom);
      load_valid = 1'($urandom);
      load_sel   = 1'($urandom);
      load_row   = 2'($urandom);
      load_data  = $urandom;
    end
    @(negedge clk);
    start      = 1'b0;
    load_valid = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    check_zero_outputs("post_rst");

    // Unloaded pass: all operands zero.
    run_pass(0, 1'b0, 32'd0);

    // Skew pattern: A[i][k] = 4i+k+1, B = identity.
    for (int r = 0; r < 4; r++) begin
      do_load(1'b0, r, {8'(4*r+4), 8'(4*r+3), 8'(4*r+2), 8'(4*r+1)});
      do_load(1'b1, r, 32'd1 << (8*r));
    end
    run_pass(0, 1'b0, 32'd0);

    // Load attempt of 0xFF into A row 0 during the pass, then a back-to-back
    // pass that still sees the original A[0][0] = 1.
    run_pass(2, 1'b0, 32'd0);
    run_pass(0, 1'b0, 32'd0);
    check_val("a00_kept", {24'd0, ref_a[0][0]}, 32'd1);

    // Start plus load collision: row 0 of A = {9,9,9,9}.
    run_pass(0, 1'b1, 32'h0909_0909);

    // Randomized matrices and passes with random gated load traffic.
    for (int p = 0; p < 6; p++) begin
      for (int n = 0; n < 6; n++)
        do_load(1'($urandom), int'($urandom_range(0, 3)), $urandom);
      @(negedge clk);
      run_pass(1, 1'($urandom), $urandom);
    end

    // Mid-pass reset at FEED t=3 (cycle 5 after the start edge).
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_cycle(c);
    end
    #2 reset = 1'b0;
    #1 check_zero_outputs("mid_rst");
    clear_model();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_zero_outputs("mid_rst_hold");
      start      = 1'($urandom);
      load_valid = 1'($urandom);
      load_data  = $urandom;
    end
    @(negedge clk);
    start      = 1'b0;
    load_valid = 1'b0;
    #2 reset = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_val("no_done_after_abort", {31'd0, done}, 32'd0);
      check_val("idle_after_abort", {31'd0, busy}, 32'd0);
    end
    run_pass(0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
